uart_tx: RTL and testbench

Serial UART transmitter. It takes parallel bytes over a valid/ready handshake and drives an 8-bit asynchronous frame onto the Tx line: start bit, data, optional parity, then stop bit(s). It sits directly upstream of the team's UART receiver on the serial link and uses the same FCLK/FUART baud parameterisation. Bit timing comes from an internal clock-enable counter; no derived clocks are used.

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Brief   : UART transmitter; valid/ready byte in, start/8 data/[parity]/stop
//           frame out. Optional parity bit enabled by macro UART_PARITY_EN.
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx #(
  parameter int FCLK       = 100000000,
  parameter int FUART      = 9600,
  parameter int BIT_CYCLES = FCLK / FUART,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       Tx,
  output logic       busy
);

  localparam logic [15:0] C_BAUD_LAST = 16'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic        r_stop_cnt;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
`ifdef UART_PARITY_EN
  logic        r_parity;
`endif

  logic       w_bit_end;
  logic       w_next_bit;
  logic [7:0] w_shifted;

  assign w_bit_end  = (r_baud_cnt == C_BAUD_LAST);
  assign w_next_bit = (MSB_FIRST != 0) ? r_shift[7] : r_shift[0];
  assign w_shifted  = (MSB_FIRST != 0) ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};

  assign Tx       = r_tx;
  assign busy     = r_busy;
  assign tx_ready = ~r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= 16'd0;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (r_state == S_IDLE) begin
      r_baud_cnt <= 16'd0;
      if (tx_valid) begin
        r_shift    <= tx_data;
        r_tx       <= 1'b0;
        r_busy     <= 1'b1;
        r_bit_cnt  <= 3'd0;
        r_stop_cnt <= 1'b0;
        r_state    <= S_START;
`ifdef UART_PARITY_EN
        r_parity   <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
      end
    end else begin
      r_baud_cnt <= w_bit_end ? 16'd0 : r_baud_cnt + 16'd1;
      case (r_state)
        S_START: begin
          if (w_bit_end) begin
            r_tx    <= w_next_bit;
            r_shift <= w_shifted;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= w_next_bit;
              r_shift   <= w_shifted;
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // A second stop period is tracked by a single flag rather than a wider count.
          if (w_bit_end) begin
            if (STOP_BITS == 2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx
// Brief   : Randomized self-checking bench for uart_tx; three parameter sets.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx;

  localparam int BC = 16;
  localparam int N  = 3;
`ifdef UART_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data  [N];
  logic       valid [N];
  logic       ready [N];
  logic       tx    [N];
  logic       busy  [N];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: MSB first, 1 stop, even parity; dut1: LSB first, odd parity; dut2: 2 stops
  uart_tx #(.BIT_CYCLES(BC), .STOP_BITS(1), .MSB_FIRST(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .Tx(tx[0]), .busy(busy[0]));
  uart_tx #(.BIT_CYCLES(BC), .STOP_BITS(1), .MSB_FIRST(0), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .Tx(tx[1]), .busy(busy[1]));
  uart_tx #(.BIT_CYCLES(BC), .STOP_BITS(2), .MSB_FIRST(1), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .Tx(tx[2]), .busy(busy[2]));

  function automatic int msb_of(input int d);
    return (d == 1) ? 0 : 1;
  endfunction
  function automatic int stops_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction
  function automatic int podd_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction
  function automatic int frame_len(input int d);
    return BC * (9 + PBITS + stops_of(d));
  endfunction

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (ready[d] !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (ready[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout dut%0d: tx_ready=%b, required 1", d, ready[d]);
    end
  endtask

  task automatic accept(input int d, input logic [7:0] b, input bit hold);
    wait_ready(d);
    data[d]  = b;
    valid[d] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid[d] = 1'b0;
  endtask

  // Called just after the acceptance edge; checks Tx/busy/ready on every cycle of the frame.
  task automatic expect_frame(input int d, input logic [7:0] b, input bit scramble,
                              output int start);
    logic exp_q[$];
    bit   p, bad;
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back((msb_of(d) != 0) ? b[7-i] : b[i]);
    p = ^b;
    if (podd_of(d) != 0) p = ~p;
    if (PBITS != 0) exp_q.push_back(p);
    for (int s = 0; s < stops_of(d); s++) exp_q.push_back(1'b1);
    start = 0;
    for (int n = 0; n < exp_q.size(); n++) begin
      bad = 1'b0;
      for (int c = 0; c < BC; c++) begin
        @(negedge clk);
        if (n == 0 && c == 0) start = cyc;
        if (scramble) data[d] = 8'($urandom);
        if (tx[d] !== exp_q[n] || busy[d] !== 1'b1 || ready[d] !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL frame dut%0d byte %02h bit%0d: Tx=%b busy=%b ready=%b, required Tx=%b busy=1 ready=0",
                 d, b, n, tx[d], busy[d], ready[d], exp_q[n]);
      end
    end
  endtask

  task automatic check_idle(input int d, input string name);
    @(negedge clk);
    checks++;
    if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s dut%0d: Tx=%b busy=%b ready=%b, required 1 0 1",
               name, d, tx[d], busy[d], ready[d]);
    end
  endtask

  task automatic test_reset();
    int s;
    rst = 1'b1;
    for (int d = 0; d < N; d++) begin
      valid[d] = 1'b0;
      data[d]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d: Tx=%b busy=%b ready=%b, required 1 0 1",
                 d, tx[d], busy[d], ready[d]);
      end
    end
    rst = 1'b0;
    for (int d = 0; d < N; d++) check_idle(d, "after_reset");
    // 0xA5 MSB first: data bit 3 is 0, so the async return to 1 is visible
    accept(0, 8'hA5, 1'b0);
    repeat (4 * BC + 6) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0) begin
      errors++;
      $display("FAIL pre_abort_bit3: Tx=%b, required 0", tx[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_abort: Tx=%b busy=%b ready=%b, required 1 0 1", tx[0], busy[0], ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    accept(0, 8'h3C, 1'b0);
    expect_frame(0, 8'h3C, 1'b0, s);
    check_idle(0, "post_abort_frame_end");
  endtask

  task automatic test_single();
    int s;
    accept(0, 8'hA5, 1'b0);
    expect_frame(0, 8'hA5, 1'b0, s);
    check_idle(0, "single_end");
  endtask

  task automatic test_bit_order();
    int s;
    accept(1, 8'h01, 1'b0);
    expect_frame(1, 8'h01, 1'b0, s);
    check_idle(1, "lsb_first_end");
    accept(0, 8'h01, 1'b0);
    expect_frame(0, 8'h01, 1'b0, s);
    check_idle(0, "msb_first_end");
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    accept(0, 8'h55, 1'b1);
    expect_frame(0, 8'h55, 1'b1, s1);
    data[0] = 8'hFF;
    check_idle(0, "b2b_gap");
    @(posedge clk);
    #1 valid[0] = 1'b0;
    expect_frame(0, 8'hFF, 1'b0, s2);
    checks++;
    if (s2 - s1 !== frame_len(0) + 1) begin
      errors++;
      $display("FAIL b2b_spacing: start spacing %0d clocks, required %0d", s2 - s1, frame_len(0) + 1);
    end
    check_idle(0, "b2b_end");
  endtask

  task automatic test_parity();
    int s;
    accept(0, 8'h07, 1'b0);
    expect_frame(0, 8'h07, 1'b0, s);
    check_idle(0, "parity_even_end");
    accept(1, 8'h07, 1'b0);
    expect_frame(1, 8'h07, 1'b0, s);
    check_idle(1, "parity_odd_end");
  endtask

  task automatic test_stop2();
    int s;
    accept(2, 8'h00, 1'b0);
    expect_frame(2, 8'h00, 1'b0, s);
    check_idle(2, "stop2_end");
  endtask

  task automatic test_random();
    int s, d;
    logic [7:0] b;
    bit sc;
    for (int i = 0; i < 24; i++) begin
      d  = int'($urandom_range(0, N - 1));
      b  = 8'($urandom);
      sc = 1'($urandom_range(0, 1));
      accept(d, b, 1'b0);
      expect_frame(d, b, sc, s);
      check_idle(d, "random_end");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bit_order();
    test_back_to_back();
    test_parity();
    test_stop2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
